// File: rtl/ipml_fifo_wr_arbiter_pkg.sv
// Shared FSM encodings and width helpers for the FIFO write arbiter.
// Imported by the arbiter top and its round-robin picker.
package ipml_fifo_wr_arbiter_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int idx_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/ipml_fifo_wr_arbiter_if.sv
// Requester beats in, one FIFO write port out.
// master: producers + FIFO side; slave: the arbiter.
interface ipml_fifo_wr_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]       fifo_wr_data;
  logic                    fifo_wr_en;
  logic                    fifo_wr_vld;

  modport master (
    output req_valid, req_data, req_last,
    output fifo_wr_vld,
    input  req_ready, fifo_wr_data, fifo_wr_en
  );

  modport slave (
    input  req_valid, req_data, req_last,
    input  fifo_wr_vld,
    output req_ready, fifo_wr_data, fifo_wr_en
  );

endinterface

// File: rtl/ipml_fifo_wr_arbiter_rr.sv
// Combinational rotate-priority picker: first set req bit at or after ptr.
// Ports: req, ptr in; one-hot gnt and encoded idx out.
module ipml_rr_arbiter
  import ipml_fifo_wr_arbiter_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int GW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [GW-1:0]    idx
);

  // Scan from the far end back to ptr so the nearest hit is written last.
  always_comb begin
    int p;
    logic [GW-1:0] pi;
    gnt = '0;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      p = int'(ptr) + k;
      if (p >= N_REQ) p = p - N_REQ;
      pi = GW'(p);
      if (req[pi]) begin
        gnt     = '0;
        gnt[pi] = 1'b1;
        idx     = pi;
      end
    end
  end

endmodule

// File: rtl/ipml_fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter for a shared FIFO write port.
// Ports: clk, rst_n, bus (slave), grant_id, busy, burst_cut.
module ipml_fifo_wr_arbiter
  import ipml_fifo_wr_arbiter_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int DATA_W    = 32,
  parameter  int BURST_MAX = 256,
  localparam int GW        = idx_w(N_REQ),
  localparam int CW        = clog2(BURST_MAX + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  ipml_fifo_wr_arbiter_if.slave        bus,
  output logic [GW-1:0]                grant_id,
  output logic                         busy,
  output logic                         burst_cut
);

  logic [0:0]       state;
  logic [GW-1:0]    rr_ptr;
  logic [CW-1:0]    beat_cnt;
  logic [N_REQ-1:0] grant_oh;

  logic [N_REQ-1:0] pick_oh;
  logic [GW-1:0]    pick_idx;
  logic [GW-1:0]    next_ptr;
  logic             g_valid;
  logic             g_last;
  logic             accept;
  logic             at_max;
  logic             rel;

  ipml_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .req (bus.req_valid),
    .ptr (rr_ptr),
    .gnt (pick_oh),
    .idx (pick_idx)
  );

  assign busy    = (state == ST_BUSY);
  assign g_valid = |(grant_oh & bus.req_valid);
  assign g_last  = |(grant_oh & bus.req_last);
  assign accept  = busy & g_valid & bus.fifo_wr_vld;
  assign at_max  = (beat_cnt == CW'(BURST_MAX - 1));
  assign rel     = accept & (g_last | at_max);

  // Ready follows FIFO space only, never the requester's valid.
  assign bus.req_ready  = grant_oh & {N_REQ{busy & bus.fifo_wr_vld}};
  assign bus.fifo_wr_en = accept;

  assign next_ptr = (int'(grant_id) == N_REQ - 1) ?
                    '0 : grant_id + GW'(1);

  always_comb begin
    bus.fifo_wr_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == GW'(i))
        bus.fifo_wr_data = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      grant_oh  <= '0;
      beat_cnt  <= '0;
      burst_cut <= 1'b0;
    end else begin
      burst_cut <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (|bus.req_valid) begin
            state    <= ST_BUSY;
            grant_id <= pick_idx;
            grant_oh <= pick_oh;
            beat_cnt <= '0;
          end
        end
        ST_BUSY: begin
          if (rel) begin
            state     <= ST_IDLE;
            rr_ptr    <= next_ptr;
            beat_cnt  <= '0;
            burst_cut <= ~g_last;
          end else if (accept) begin
            beat_cnt <= beat_cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ipml_fifo_wr_arbiter.sv
// Bench for ipml_fifo_wr_arbiter: vector table, corner sequences,
// and random traffic against a packet-level reference model.
module tb_ipml_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int BM = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] grant_id;
  logic       busy;
  logic       burst_cut;

  always #5 clk = ~clk;

  ipml_fifo_wr_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

  ipml_fifo_wr_arbiter #(
    .N_REQ     (N),
    .DATA_W    (DW),
    .BURST_MAX (BM)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .grant_id  (grant_id),
    .busy      (busy),
    .burst_cut (burst_cut)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic logic [40:0] outs();
    return {busy, grant_id, bus.req_ready,
            bus.fifo_wr_en, burst_cut, bus.fifo_wr_data};
  endfunction

  task automatic drive(input logic [3:0] v, input logic [3:0] l,
                       input logic w, input int tag);
    bus.req_valid   = v;
    bus.req_last    = l;
    bus.fifo_wr_vld = w;
    for (int i = 0; i < N; i++)
      bus.req_data[i*DW +: DW] = {8'(i), 24'(tag)};
  endtask

  typedef struct {
    logic [3:0] v;
    logic [3:0] l;
    logic       w;
    logic       eb;
    logic [1:0] eg;
    logic [3:0] er;
    logic       ee;
    logic       ec;
  } vec_t;

  vec_t vq[$];

  task automatic row(input logic [3:0] v, input logic [3:0] l,
                     input logic w, input logic eb,
                     input logic [1:0] eg, input logic [3:0] er,
                     input logic ee, input logic ec);
    vec_t r;
    r.v = v; r.l = l; r.w = w; r.eb = eb;
    r.eg = eg; r.er = er; r.ee = ee; r.ec = ec;
    vq.push_back(r);
  endtask

  // reference model state (packet level)
  bit m_busy, m_cut;
  int m_g, m_ptr, m_n;

  logic [3:0]  rv, rl, er;
  logic        rw, ee;
  logic [31:0] rd [N];
  int          order[$];
  int          rise[$];
  int          bcnt[N];
  logic        prev_busy;
  int          p;

  initial begin
    drive(4'b0, 4'b0, 1'b1, 0);
    repeat (2) @(negedge clk);
    #1 check("reset_hold", 64'(outs()), 64'({9'b0, 32'h0}));
    rst_n = 1'b1;

    // single port, round robin, burst cut, backpressure, stall
    row(4'b0100, 4'b0000, 1, 0, 0, 4'b0000, 0, 0);
    repeat (3) row(4'b0100, 4'b0000, 1, 1, 2, 4'b0100, 1, 0);
    row(4'b0100, 4'b0100, 1, 1, 2, 4'b0100, 1, 0);
    row(4'b1111, 4'b1000, 1, 0, 2, 4'b0000, 0, 0);
    row(4'b1011, 4'b1000, 1, 1, 3, 4'b1000, 1, 0);
    row(4'b0011, 4'b0011, 1, 0, 3, 4'b0000, 0, 0);
    row(4'b0011, 4'b0011, 1, 1, 0, 4'b0001, 1, 0);
    row(4'b0010, 4'b0000, 1, 0, 0, 4'b0000, 0, 0);
    repeat (4) row(4'b0010, 4'b0000, 1, 1, 1, 4'b0010, 1, 0);
    row(4'b0010, 4'b0000, 1, 0, 1, 4'b0000, 0, 1);
    repeat (4) row(4'b0010, 4'b0000, 1, 1, 1, 4'b0010, 1, 0);
    row(4'b0010, 4'b0000, 1, 0, 1, 4'b0000, 0, 1);
    row(4'b0010, 4'b0000, 1, 1, 1, 4'b0010, 1, 0);
    row(4'b0010, 4'b0010, 1, 1, 1, 4'b0010, 1, 0);
    row(4'b0100, 4'b0000, 1, 0, 1, 4'b0000, 0, 0);
    repeat (2) row(4'b0100, 4'b0000, 1, 1, 2, 4'b0100, 1, 0);
    repeat (5) row(4'b0100, 4'b0000, 0, 1, 2, 4'b0000, 0, 0);
    repeat (2) row(4'b0100, 4'b0000, 1, 1, 2, 4'b0100, 1, 0);
    row(4'b0100, 4'b0000, 1, 0, 2, 4'b0000, 0, 1);
    row(4'b0100, 4'b0100, 1, 1, 2, 4'b0100, 1, 0);
    row(4'b1001, 4'b0000, 1, 0, 2, 4'b0000, 0, 0);
    row(4'b1001, 4'b0000, 1, 1, 3, 4'b1000, 1, 0);
    repeat (3) row(4'b0001, 4'b0000, 1, 1, 3, 4'b1000, 0, 0);
    row(4'b1001, 4'b1000, 1, 1, 3, 4'b1000, 1, 0);
    row(4'b0001, 4'b0001, 1, 0, 3, 4'b0000, 0, 0);
    row(4'b0001, 4'b0001, 1, 1, 0, 4'b0001, 1, 0);
    row(4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 0, 0);

    for (int k = 0; k < vq.size(); k++) begin
      @(negedge clk);
      drive(vq[k].v, vq[k].l, vq[k].w, k);
      #1 check($sformatf("vec%0d", k), 64'(outs()),
               64'({vq[k].eb, vq[k].eg, vq[k].er, vq[k].ee,
                    vq[k].ec, 8'(vq[k].eg), 24'(k)}));
    end

    // async reset mid-burst, then arbitration restarts at port 0
    @(negedge clk);
    drive(4'b1000, 4'b0000, 1'b1, 100);
    @(negedge clk);
    #1 check("rst_pre", 64'({busy, grant_id}), 64'({1'b1, 2'd3}));
    #2 rst_n = 1'b0;
    #1 check("rst_async", 64'(outs()), 64'({9'b0, 8'd0, 24'd100}));
    @(negedge clk);
    drive(4'b1111, 4'b0000, 1'b1, 101);
    rst_n = 1'b1;
    @(negedge clk);
    #1 check("rst_ptr0", 64'({busy, grant_id}), 64'({1'b1, 2'd0}));
    drive(4'b0001, 4'b0001, 1'b1, 102);
    @(negedge clk);
    drive(4'b0000, 4'b0000, 1'b1, 103);

    // fairness: all ports valid, 2-beat packets
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < N; i++) bcnt[i] = 0;
    prev_busy = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) rl[i] = bcnt[i][0];
      drive(4'b1111, rl, 1'b1, c);
      #1;
      if (busy && !prev_busy) begin
        order.push_back(int'(grant_id));
        rise.push_back(c);
      end
      prev_busy = busy;
      for (int i = 0; i < N; i++)
        if (bus.req_ready[i]) bcnt[i]++;
    end
    check("rr_count", 64'(order.size() >= 8), 64'(1));
    for (int k = 0; k < 8 && k < order.size(); k++) begin
      check($sformatf("rr_order%0d", k), 64'(order[k]), 64'(k % N));
      if (k > 0)
        check($sformatf("rr_gap%0d", k),
              64'(rise[k] - rise[k-1]), 64'(3));
    end

    // random traffic vs packet-level model
    @(negedge clk) rst_n = 1'b0;
    drive(4'b0, 4'b0, 1'b1, 0);
    @(negedge clk) rst_n = 1'b1;
    m_busy = 0; m_cut = 0; m_g = 0; m_ptr = 0; m_n = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rv = 4'($urandom);
      rl = 4'($urandom & $urandom);
      rw = ($urandom_range(0, 9) < 8);
      bus.req_valid   = rv;
      bus.req_last    = rl;
      bus.fifo_wr_vld = rw;
      for (int i = 0; i < N; i++) begin
        rd[i] = $urandom;
        bus.req_data[i*DW +: DW] = rd[i];
      end
      er = (m_busy && rw) ? 4'(1 << m_g) : 4'b0;
      ee = m_busy && rv[m_g] && rw;
      #1 check($sformatf("rand%0d", c), 64'(outs()),
               64'({m_busy, 2'(m_g), er, ee, m_cut, rd[m_g]}));
      // advance the model by one clock
      if (!m_busy) begin
        m_cut = 0;
        if (rv != 0) begin
          for (int k = N - 1; k >= 0; k--) begin
            p = (m_ptr + k) % N;
            if (rv[p]) m_g = p;
          end
          m_busy = 1;
          m_n = 0;
        end
      end else if (ee) begin
        m_n++;
        if (rl[m_g] || m_n == BM) begin
          m_cut  = !rl[m_g];
          m_busy = 0;
          m_ptr  = (m_g + 1) % N;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
